// File: rtl/wl_dec_pkg.sv
// wl_dec_pkg: shared FSM encoding, counter width and default timing for the word-line pulse decoder.
package wl_dec_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 1;
endpackage

// File: rtl/wl_range_dec.sv
// wl_range_dec: combinational decode of lines base..base+rows, clipped at NUM_WORDS-1.
module wl_range_dec
  import wl_dec_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0]    base,
  input  logic [CNT_W-1:0]     rows,
  output logic [NUM_WORDS-1:0] mask
);
  logic [ADDR_W:0] lo, hi;
  assign lo = {1'b0, base};
  assign hi = lo + (ADDR_W+1)'(rows);
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_bit
    assign mask[i] = ((ADDR_W+1)'(i) >= lo) && ((ADDR_W+1)'(i) <= hi);
  end
endmodule

// File: rtl/wordline_pulse_decoder.sv
// wordline_pulse_decoder: setup/pulse/hold word-line sequencer; WL_MULTIROW_EN adds req_rows for multi-line pulses.
module wordline_pulse_decoder
  import wl_dec_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
`ifdef WL_MULTIROW_EN
  input  logic [3:0]           req_rows,
`endif
  output logic [NUM_WORDS-1:0] wl,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC == 0 ? 0 : SETUP_CYC - 1);
  localparam cnt_t PULSE_LD = cnt_t'(PULSE_CYC - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC == 0 ? 0 : HOLD_CYC - 1);
  state_t state, state_d;
  cnt_t cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, base;
  cnt_t rows_q, rows_in, rows_sel;
  logic started, hs, bad;
  logic [NUM_WORDS-1:0] mask;
`ifdef WL_MULTIROW_EN
  assign rows_in = req_rows;
`else
  assign rows_in = '0;
`endif
  assign req_ready = started && state == IDLE;
  assign busy = state != IDLE;
  assign hs = req_valid && req_ready;
  assign bad = {1'b0, req_addr} >= (ADDR_W+1)'(NUM_WORDS);
  // IDLE decodes the live request so a zero-setup pulse can start on the handshake edge
  assign base = state == IDLE ? req_addr : addr_q;
  assign rows_sel = state == IDLE ? rows_in : rows_q;
  wl_range_dec #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) u_dec (
    .base(base),
    .rows(rows_sel),
    .mask(mask)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: if (hs && !bad) begin
        state_d = SETUP_CYC == 0 ? ACTIVE : SETUP;
        cnt_d = SETUP_CYC == 0 ? PULSE_LD : SETUP_LD;
      end
      SETUP: begin
        state_d = cnt == '0 ? ACTIVE : SETUP;
        cnt_d = cnt == '0 ? PULSE_LD : cnt - 1'b1;
      end
      ACTIVE: begin
        state_d = cnt != '0 ? ACTIVE : HOLD_CYC == 0 ? IDLE : HOLD;
        cnt_d = cnt != '0 ? cnt - 1'b1 : HOLD_LD;
      end
      HOLD: begin
        state_d = cnt == '0 ? IDLE : HOLD;
        cnt_d = cnt == '0 ? '0 : cnt - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rows_q <= '0;
      wl <= '0;
      done <= 1'b0;
      err <= 1'b0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      state <= state_d;
      cnt <= cnt_d;
      if (hs) begin
        addr_q <= req_addr;
        rows_q <= rows_in;
      end
      wl <= state_d == ACTIVE ? mask : '0;
      done <= state != IDLE && state_d == IDLE;
      err <= hs && bad;
    end
  end
endmodule

// File: tb/tb_wordline_pulse_decoder.sv
// tb_wordline_pulse_decoder: directed checks on default, NUM_WORDS=1000 and zero-setup/hold instances.
module tb_wordline_pulse_decoder;
  logic clk = 0;
  logic rst_n = 0;
  logic v0 = 0, v1 = 0, v2 = 0;
  logic [9:0] addr = '0;
  logic [3:0] rows = '0;
  logic r0, b0, dn0, e0, r1, b1, dn1, e1, r2, b2, dn2, e2;
  logic [1023:0] w0, w2;
  logic [999:0] w1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  wordline_pulse_decoder d0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_addr(addr),
`ifdef WL_MULTIROW_EN
    .req_rows(rows),
`endif
    .wl(w0), .busy(b0), .done(dn0), .err(e0));
  wordline_pulse_decoder #(.NUM_WORDS(1000)) d1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_addr(addr),
`ifdef WL_MULTIROW_EN
    .req_rows(rows),
`endif
    .wl(w1), .busy(b1), .done(dn1), .err(e1));
  wordline_pulse_decoder #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) d2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(r2), .req_addr(addr),
`ifdef WL_MULTIROW_EN
    .req_rows(rows),
`endif
    .wl(w2), .busy(b2), .done(dn2), .err(e2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #3;
    checks++;
    if ({r0, b0, dn0, e0, r1, b1, dn1, e1, r2, b2, dn2, e2} !== 12'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0", {r0, b0, dn0, e0, r1, b1, dn1, e1, r2, b2, dn2, e2});
    end
    checks++;
    if (w0 !== '0 || w1 !== '0 || w2 !== '0) begin
      failures++;
      $display("FAIL reset_wl got nonzero want=0");
    end
    tick();
    rst_n = 1;
    checks++;
    if (r0 !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge got=%b want=0", r0);
    end
    tick();
    checks++;
    if ({r0, r1, r2} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset got=%b want=111", {r0, r1, r2});
    end
  endtask
  task automatic test_single();
    logic [1023:0] e;
    addr = 5;
    v0 = 1;
    tick();
    addr = 7;
    checks++;
    if (b0 !== 1'b1 || r0 !== 1'b0 || w0 !== '0) begin
      failures++;
      $display("FAIL single_setup got busy=%b ready=%b wl_nz=%b want 1 0 0", b0, r0, |w0);
    end
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (c == 7) v0 = 0;
      e = '0;
      if (c >= 3 && c <= 6) e[5] = 1'b1;
      checks++;
      if (w0 !== e) begin
        failures++;
        $display("FAIL single_wl cycle=%0d got_count=%0d got5=%b want5=%b", c, $countones(w0), w0[5], e[5]);
      end
      checks++;
      if (dn0 !== (c == 8) || b0 !== (c < 8)) begin
        failures++;
        $display("FAIL single_done cycle=%0d got done=%b busy=%b want %b %b", c, dn0, b0, c == 8, c < 8);
      end
    end
    tick();
    checks++;
    if (dn0 !== 1'b0 || b0 !== 1'b0) begin
      failures++;
      $display("FAIL single_after got done=%b busy=%b want 0 0", dn0, b0);
    end
  endtask
  task automatic test_back_to_back();
    logic [1023:0] e;
    int a;
    addr = 1023;
    v0 = 1;
    for (int k = 0; k < 2; k++) begin
      a = k == 0 ? 1023 : 0;
      tick();
      v0 = 0;
      checks++;
      if (w0 !== '0 || b0 !== 1'b1) begin
        failures++;
        $display("FAIL b2b_setup seq=%0d got busy=%b wl_nz=%b want 1 0", k, b0, |w0);
      end
      for (int c = 3; c <= 8; c++) begin
        tick();
        e = '0;
        if (c >= 3 && c <= 6) e[a] = 1'b1;
        checks++;
        if (w0 !== e) begin
          failures++;
          $display("FAIL b2b_wl seq=%0d cycle=%0d got_count=%0d want_bit=%0d", k, c, $countones(w0), a);
        end
        if (c == 8) begin
          checks++;
          if (dn0 !== 1'b1 || r0 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done seq=%0d got done=%b ready=%b want 1 1", k, dn0, r0);
          end
          if (k == 0) begin
            addr = 0;
            v0 = 1;
          end
        end
      end
    end
    tick();
  endtask
  task automatic test_err();
    addr = 1000;
    v1 = 1;
    tick();
    v1 = 0;
    checks++;
    if (e1 !== 1'b1 || w1 !== '0 || r1 !== 1'b1 || b1 !== 1'b0 || dn1 !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got err=%b ready=%b busy=%b done=%b wl_nz=%b want 1 1 0 0 0", e1, r1, b1, dn1, |w1);
    end
    tick();
    checks++;
    if (e1 !== 1'b0 || dn1 !== 1'b0 || b1 !== 1'b0) begin
      failures++;
      $display("FAIL err_after got err=%b done=%b busy=%b want 0 0 0", e1, dn1, b1);
    end
    addr = 999;
    v1 = 1;
    tick();
    v1 = 0;
    checks++;
    if (e1 !== 1'b0 || b1 !== 1'b1) begin
      failures++;
      $display("FAIL err_last_ok got err=%b busy=%b want 0 1", e1, b1);
    end
    for (int c = 3; c <= 8; c++) begin
      tick();
      if (c == 3) begin
        checks++;
        if (w1[999] !== 1'b1 || $countones(w1) != 1) begin
          failures++;
          $display("FAIL err_last_wl got bit=%b count=%0d want 1 1", w1[999], $countones(w1));
        end
      end
    end
    checks++;
    if (dn1 !== 1'b1) begin
      failures++;
      $display("FAIL err_last_done got=%b want=1", dn1);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    addr = 3;
    v0 = 1;
    tick();
    v0 = 0;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (w0 !== '0 || b0 !== 1'b0 || r0 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_now got busy=%b ready=%b wl_nz=%b want 0 0 0", b0, r0, |w0);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dn0 !== 1'b0 || w0 !== '0 || b0 !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after i=%0d got done=%b busy=%b wl_nz=%b want 0 0 0", i, dn0, b0, |w0);
      end
    end
  endtask
  task automatic test_zero_timing();
    logic [1023:0] e;
    e = '0;
    e[9] = 1'b1;
    addr = 9;
    v2 = 1;
    tick();
    v2 = 0;
    checks++;
    if (w2 !== e || b2 !== 1'b1) begin
      failures++;
      $display("FAIL zero_wl got bit=%b count=%0d busy=%b want 1 1 1", w2[9], $countones(w2), b2);
    end
    tick();
    checks++;
    if (w2 !== '0 || dn2 !== 1'b1 || r2 !== 1'b1) begin
      failures++;
      $display("FAIL zero_done got done=%b ready=%b wl_nz=%b want 1 1 0", dn2, r2, |w2);
    end
    tick();
    checks++;
    if (dn2 !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got done=%b want 0", dn2);
    end
  endtask
`ifdef WL_MULTIROW_EN
  task automatic test_multirow();
    logic [1023:0] e;
    e = '0;
    e[1023:1020] = 4'hF;
    addr = 1020;
    rows = 7;
    v0 = 1;
    tick();
    v0 = 0;
    rows = 0;
    tick();
    checks++;
    if (w0 !== e) begin
      failures++;
      $display("FAIL multirow_wl got hi=%h lo=%h count=%0d want hi=f lo=0", w0[1023:1020], w0[3:0], $countones(w0));
    end
    for (int c = 4; c <= 8; c++) tick();
    checks++;
    if (dn0 !== 1'b1 || w0 !== '0) begin
      failures++;
      $display("FAIL multirow_done got done=%b wl_nz=%b want 1 0", dn0, |w0);
    end
    tick();
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_zero_timing();
`ifdef WL_MULTIROW_EN
    test_multirow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wordline_pulse_decoder.md
WORDLINE_PULSE_DECODER -- requirements
Module: wordline_pulse_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning request address width.
REQ-002 SHALL have parameter NUM_WORDS, default 1024, meaning word lines driven; legal range 2..2**ADDR_W.
REQ-003 SHALL have parameter SETUP_CYC, default 1, meaning cycles with all lines low before assertion; legal range 0..15.
REQ-004 SHALL have parameter PULSE_CYC, default 4, meaning cycles the selected line(s) stay high; legal range 1..15.
REQ-005 SHALL have parameter HOLD_CYC, default 1, meaning cycles with all lines low after deassertion; legal range 0..15.
REQ-006 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port req_valid, input, 1, request present.
REQ-009 SHALL have port req_ready, output, 1, block can accept a request.
REQ-010 SHALL have port req_addr, input, ADDR_W, first word line to activate.
REQ-011 SHALL have port wl, output, NUM_WORDS, registered word-line enables.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of a sequence.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a rejected request.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACTIVE, HOLD.
REQ-016 SHALL drive req_ready=1 only in IDLE; handshake is req_valid&&req_ready on a rising edge.
REQ-017 SHALL latch req_addr (and req_rows when present) on handshake; later input changes are ignored until the next handshake.
REQ-018 SHALL reject a request with req_addr>=NUM_WORDS: err=1 next cycle, state stays IDLE, wl stays zero, no done.
REQ-019 SHALL on an accepted request go IDLE->SETUP for exactly SETUP_CYC cycles; SETUP_CYC=0 goes directly to ACTIVE.
REQ-020 SHALL hold ACTIVE exactly PULSE_CYC cycles with wl equal to the decoded selection; wl zero in every other state.
REQ-021 SHALL then hold HOLD for HOLD_CYC cycles (skipped when 0), then return to IDLE with done=1 for the first IDLE cycle.
REQ-022 SHALL use one 4-bit down-counter shared by SETUP/ACTIVE/HOLD, loaded on each state entry.
REQ-023 SHALL assert wl registered: first ACTIVE cycle shows the line, no combinational path from req_* to wl.
REQ-024 SHALL accept a new request in the same cycle done is high (back-to-back; done and req_ready both 1).
REQ-025 SHALL make req_valid during busy have no effect.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE, wl=0, counter=0, latched address=0, busy=0, done=0, err=0, req_ready=0.
REQ-027 SHALL drive req_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-028 SHALL on reset mid-sequence drop all word lines at once and produce no done.

Configuration
REQ-029 SHALL support macro WL_MULTIROW_EN: when defined, add input req_rows [3:0]; ACTIVE asserts lines req_addr..req_addr+req_rows inclusive.
REQ-030 SHALL with WL_MULTIROW_EN clip the range at NUM_WORDS-1, never wrap to line 0.
REQ-031 SHALL without WL_MULTIROW_EN omit req_rows entirely and assert exactly one line (one-hot).

Structure
REQ-032 SHALL place state encoding (2-bit enum), counter width and default timing constants in package wl_dec_pkg.
REQ-033 SHALL implement decoding in sub-module wl_range_dec (combinational; inputs base, rows; output NUM_WORDS mask).

Verification
REQ-034 SHALL cover: defaults, req_addr=5 -> wl[5] high cycles 3..6 after handshake, done at cycle 8, no other bit ever set.
REQ-035 SHALL cover: req_addr=1023 then req_addr=0 back-to-back on done cycle -> wl[1023] then wl[0] pulses, no overlap.
REQ-036 SHALL cover: NUM_WORDS=1000, req_addr=1000 -> err one cycle, wl=0, req_ready stays 1, no done.
REQ-037 SHALL cover: rst_n low in 2nd ACTIVE cycle -> wl=0 before next edge, busy=0, no done after release.
REQ-038 SHALL cover: WL_MULTIROW_EN, req_addr=1020, req_rows=7 -> wl[1023:1020] high, wl[3:0] low.
REQ-039 SHALL cover: SETUP_CYC=0, HOLD_CYC=0, PULSE_CYC=1 -> wl high one cycle after handshake, done next cycle.
